// File: rtl/eth_test_frame_gen_pkg.sv
// rtl/eth_test_frame_gen_pkg.sv - states and constants shared by the MII test-frame generator
package eth_test_frame_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        HEADER,
        PAYLOAD,
        FCS,
        IFG
    } state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
    localparam logic [31:0] CRC_POLY        = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE     = 32'hDEBB_20E3;
    localparam int          HEADER_NIBBLES  = 28;

endpackage

// File: rtl/eth_crc32_nibble.sv
// rtl/eth_crc32_nibble.sv - combinational reflected CRC-32 step over one nibble, LSB first
module eth_crc32_nibble
    import eth_test_frame_gen_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc;
        for (int i = 0; i < 4; i++) begin
            c = (c[0] ^ nibble[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
    end

    assign crc_next = c;

endmodule

// File: rtl/eth_test_frame_gen.sv
// rtl/eth_test_frame_gen.sv - back-to-back MII test-frame generator; FCS transmitted when ETH_TEST_FRAME_GEN_FCS_EN is defined
module eth_test_frame_gen
    import eth_test_frame_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          PAYLOAD_LEN = 46,
    parameter int          IFG_NIBBLES = 24
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    output logic [3:0]  eth_txd_out,
    output logic        eth_tx_en_out,
    output logic        busy_out,
    output logic [15:0] frame_count_out
);

    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [15:0]  PRE_LAST = 16'd14;
    localparam logic [15:0]  HDR_LAST = 16'(HEADER_NIBBLES - 1);
    localparam logic [15:0]  PAY_LAST = 16'(2 * PAYLOAD_LEN - 1);
    localparam logic [15:0]  FCS_LAST = 16'd7;
    localparam logic [15:0]  IFG_LAST = 16'(IFG_NIBBLES - 1);

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [3:0]  txd, nibble;
    logic        tx_en, nibble_en, busy;
    logic [15:0] frame_count;
    logic [6:0]  hdr_lsb;
    logic [7:0]  hdr_byte, pay_byte;
    logic [10:0] pay_idx;

    // Header bytes go out MSB byte first, so byte b sits at bit 8*(13-b).
    assign hdr_lsb  = 7'(8 * (13 - int'(cnt[4:1])));
    assign hdr_byte = 8'(HDR >> hdr_lsb);
    assign pay_idx  = cnt[11:1];
    assign pay_byte = (pay_idx == 11'd0) ? frame_count[15:8] :
                      (pay_idx == 11'd1) ? frame_count[7:0]  : pay_idx[7:0];

`ifdef ETH_TEST_FRAME_GEN_FCS_EN
    logic [31:0] crc, crc_next, fcs;

    eth_crc32_nibble u_crc (
        .crc      (crc),
        .nibble   (nibble),
        .crc_next (crc_next)
    );

    assign fcs = ~crc;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 16'd1;
        nibble     = 4'h0;
        nibble_en  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (enable_in) state_next = PREAMBLE;
            end
            PREAMBLE: begin
                nibble_en = 1'b1;
                nibble    = PREAMBLE_NIBBLE;
                if (cnt == PRE_LAST) begin
                    state_next = SFD;
                    cnt_next   = '0;
                end
            end
            SFD: begin
                nibble_en  = 1'b1;
                nibble     = SFD_NIBBLE;
                state_next = HEADER;
                cnt_next   = '0;
            end
            HEADER: begin
                nibble_en = 1'b1;
                nibble    = cnt[0] ? hdr_byte[7:4] : hdr_byte[3:0];
                if (cnt == HDR_LAST) begin
                    state_next = PAYLOAD;
                    cnt_next   = '0;
                end
            end
            PAYLOAD: begin
                nibble_en = 1'b1;
                nibble    = cnt[0] ? pay_byte[7:4] : pay_byte[3:0];
                if (cnt == PAY_LAST) begin
`ifdef ETH_TEST_FRAME_GEN_FCS_EN
                    state_next = FCS;
`else
                    state_next = IFG;
`endif
                    cnt_next   = '0;
                end
            end
            FCS: begin
`ifdef ETH_TEST_FRAME_GEN_FCS_EN
                nibble_en = 1'b1;
                nibble    = fcs[{cnt[2:0], 2'b00} +: 4];
                if (cnt == FCS_LAST) begin
                    state_next = IFG;
                    cnt_next   = '0;
                end
`else
                state_next = IFG;
                cnt_next   = '0;
`endif
            end
            IFG: begin
                if (cnt == IFG_LAST) begin
                    state_next = enable_in ? PREAMBLE : IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs lag the state by one register; frames are counted on the first IFG cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            cnt         <= '0;
            txd         <= 4'h0;
            tx_en       <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            txd   <= nibble;
            tx_en <= nibble_en;
            busy  <= (state_next != IDLE);
            if (state == IFG && cnt == '0) frame_count <= frame_count + 16'd1;
        end
    end

`ifdef ETH_TEST_FRAME_GEN_FCS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in || state == SFD) crc <= CRC_INIT;
        else if (state == HEADER || state == PAYLOAD) crc <= crc_next;
    end
`endif

    assign eth_txd_out     = txd;
    assign eth_tx_en_out   = tx_en;
    assign busy_out        = busy;
    assign frame_count_out = frame_count;

endmodule

// File: tb/tb_eth_test_frame_gen.sv
// tb/tb_eth_test_frame_gen.sv - scoreboard bench for eth_test_frame_gen; FCS residue checked when ETH_TEST_FRAME_GEN_FCS_EN is defined
module tb_eth_test_frame_gen;

`ifdef ETH_TEST_FRAME_GEN_FCS_EN
    localparam int FLEN = 144;
`else
    localparam int FLEN = 136;
`endif
    localparam int DATA_END = 136;
    localparam logic [3:0] HDR_NIBS [28] = '{
        4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
        4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0,
        4'h8, 4'h8, 4'h5, 4'hB};

    typedef struct {
        logic [15:0] stamp;
        int          len;
        bit          aborted;
        bit          chk_gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  txd;
    logic        tx_en;
    logic        busy;
    logic [15:0] fc;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [3:0]  cap[$];
    bit          in_frame = 1'b0;
    int          gap = 0;
    int          frame_gap = 0;

    eth_test_frame_gen dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .enable_in       (en),
        .eth_txd_out     (txd),
        .eth_tx_en_out   (tx_en),
        .busy_out        (busy),
        .frame_count_out (fc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_nib(input int idx, input logic [15:0] stamp);
        int p;
        logic [7:0] b;
        if (idx < 15) return 4'h5;
        if (idx == 15) return 4'hD;
        if (idx < 44) return HDR_NIBS[idx - 16];
        p = idx - 44;
        if (p / 2 == 0) b = stamp[15:8];
        else if (p / 2 == 1) b = stamp[7:0];
        else b = 8'(p / 2);
        return (p % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [3:0] d);
        logic [31:0] c;
        c = c_in;
        for (int b = 0; b < 4; b++) c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    task automatic check_frame();
        exp_t e;
        int   n;
        int   bad;
        logic [31:0] rx_crc;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got frame of %0d nibbles, expected none", cap.size());
            return;
        end
        e = sb.pop_front();
        check($sformatf("frame_%04h length", e.stamp), cap.size(), e.len);
        n = (cap.size() < DATA_END) ? cap.size() : DATA_END;
        bad = -1;
        for (int i = 0; i < n; i++) if (bad < 0 && cap[i] !== exp_nib(i, e.stamp)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL frame_%04h nibble %0d: got %h expected %h", e.stamp, bad, cap[bad], exp_nib(bad, e.stamp));
        end
`ifdef ETH_TEST_FRAME_GEN_FCS_EN
        if (!e.aborted) begin
            rx_crc = 32'hFFFF_FFFF;
            for (int i = 16; i < cap.size(); i++) rx_crc = crc_step(rx_crc, cap[i]);
            check($sformatf("frame_%04h fcs residue", e.stamp), rx_crc, 32'hDEBB_20E3);
        end
`endif
        check($sformatf("frame_%04h count after", e.stamp), fc, e.aborted ? e.stamp : 16'(e.stamp + 16'd1));
        check($sformatf("frame_%04h txd idle", e.stamp), txd, 4'h0);
        if (e.chk_gap) check($sformatf("frame_%04h gap", e.stamp), frame_gap, 24);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (tx_en) begin
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    frame_gap = gap;
                    cap.delete();
                end
                cap.push_back(txd);
            end else if (in_frame) begin
                in_frame = 1'b0;
                gap      = 1;
                check_frame();
            end else begin
                gap++;
            end
        end
    end

    task automatic push(input logic [15:0] stamp, input int len, input bit aborted, input bit chk_gap);
        exp_t e;
        e.stamp   = stamp;
        e.len     = len;
        e.aborted = aborted;
        e.chk_gap = chk_gap;
        sb.push_back(e);
    endtask

    task automatic wait_tx_high(input int n, input string what);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (tx_en) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: saw %0d of %0d TX_EN samples", what, seen, n);
        end
    endtask

    task automatic wait_tx_low(input string what);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (tx_en && cyc < 3000);
        if (tx_en) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: TX_EN still %0b, expected 0", what, tx_en);
        end
    endtask

    task automatic wait_sb_empty(input string what);
        int cyc = 0;
        while (sb.size() != 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: %0d frames outstanding, expected 0", what, sb.size());
        end
    endtask

    initial begin : stimulus
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset tx_en", tx_en, 1'b0);
            check("reset txd", txd, 4'h0);
            check("reset busy", busy, 1'b0);
            check("reset frame_count", fc, 16'h0000);
        end

        // Release with enable high, then abort the frame in its payload.
        push(16'h0000, 60, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("release+1 tx_en", tx_en, 1'b0);
        check("release+1 busy", busy, 1'b1);
        @(negedge clk);
        check("release+2 tx_en", tx_en, 1'b1);
        check("release+2 txd", txd, 4'h5);
        wait_tx_high(59, "abort");
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        check("abort tx_en", tx_en, 1'b0);
        check("abort frame_count", fc, 16'h0000);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Four back-to-back frames; enable dropped at header nibble 10 of the last.
        push(16'h0000, FLEN, 1'b0, 1'b0);
        push(16'h0001, FLEN, 1'b0, 1'b1);
        push(16'h0002, FLEN, 1'b0, 1'b1);
        push(16'h0003, FLEN, 1'b0, 1'b1);
        en = 1'b1;
        wait_tx_high(3 * FLEN + 27, "continuous");
        en = 1'b0;
        wait_tx_low("last_frame");
        repeat (22) @(negedge clk);
        check("ifg busy", busy, 1'b1);
        @(negedge clk);
        check("after ifg busy", busy, 1'b0);
        check("after ifg tx_en", tx_en, 1'b0);
        wait_sb_empty("continuous");

        // Single one-cycle enable pulse.
        push(16'h0004, FLEN, 1'b0, 1'b0);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_sb_empty("single");
        repeat (30) @(negedge clk);
        check("single idle busy", busy, 1'b0);
        check("single frame_count", fc, 16'h0005);

        // Counter wrap from 16'hFFFF.
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        @(negedge clk);
        check("wrap preload", fc, 16'hFFFF);
        push(16'hFFFF, FLEN, 1'b0, 1'b0);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_sb_empty("wrap");
        repeat (30) @(negedge clk);
        check("wrap frame_count", fc, 16'h0000);
        check("final busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_test_frame_gen.md
Name: eth_test_frame_gen

Overview:
- Self-contained Ethernet test-frame generator.
- Emits back-to-back MII transmit frames as one nibble per clk_in cycle; clk_in is the 25 MHz PHY transmit clock.
- Each frame: preamble, SFD, fixed MAC/EtherType header, counter-stamped payload, FCS, then inter-frame gap.
- Sits directly in front of the PHY TX pins; used for board bring-up and loopback testing.

Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, sent MSB byte first.
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC, sent MSB byte first.
- ETHERTYPE, 16'h88B5, EtherType field, sent MSB byte first.
- PAYLOAD_LEN, 46, payload bytes; legal range 46..1500.
- IFG_NIBBLES, 24, idle nibbles after each frame; minimum 24.

Ports:
- clk_in  input  1  single clock, all logic on rising edge.
- rst_in  input  1  synchronous reset, active-high.
- enable_in  input  1  level; while high, frames are generated continuously.
- eth_txd_out  output  4  MII TXD nibble.
- eth_tx_en_out  output  1  MII TX_EN.
- busy_out  output  1  high whenever state is not IDLE.
- frame_count_out  output  16  number of completed frames, wraps at 16'hFFFF to 0.

Behaviour:
- Reset values:
  - eth_txd_out = 0, eth_tx_en_out = 0, busy_out = 0, frame_count_out = 0.
  - State = IDLE; CRC register = 32'hFFFF_FFFF.
- Reset applies on the next edge, even mid-frame: TX_EN drops with no FCS; the frame is not counted.
- All outputs are registered.
- Byte serialisation: every byte is sent low nibble first, then high nibble.
- States:
  - IDLE -> PREAMBLE when enable_in is sampled high. The first preamble nibble appears with TX_EN high on the following cycle.
  - PREAMBLE: 15 nibbles of 4'h5.
  - SFD: 1 nibble of 4'hD.
  - HEADER: 28 nibbles, carrying DST_MAC, SRC_MAC, ETHERTYPE.
  - PAYLOAD: 2*PAYLOAD_LEN nibbles.
    - Bytes 0-1 = current frame_count_out value, MSB byte first.
    - Byte i (i >= 2) = i[7:0].
  - FCS: 8 nibbles (see Optional Feature).
  - IFG: IFG_NIBBLES cycles with TX_EN = 0 and TXD = 0.
    - Exit to PREAMBLE if enable_in is high on the last IFG cycle, else to IDLE.
- TX_EN is high from the first preamble nibble through the last FCS nibble, contiguous; no gaps inside a frame.
- frame_count_out increments on the cycle after the last FCS nibble. The payload stamp uses the pre-increment value: first frame carries 0x0000.
- enable_in deasserted mid-frame: the current frame completes normally, including IFG, then the block returns to IDLE.
- CRC-32 (IEEE 802.3):
  - Reflected polynomial 32'hEDB8_8320, initial value 32'hFFFF_FFFF.
  - Updated one nibble per cycle, LSB first, over HEADER and PAYLOAD nibbles only.
  - Reinitialised in SFD.
  - FCS = bitwise complement of the CRC register, sent bits [3:0] first up to [31:28].
- Frame length at defaults: 8 bytes preamble/SFD + 64 bytes frame = 144 nibbles of TX_EN; 168-cycle frame period including IFG.

Optional Feature:
- Macro: ETH_TEST_FRAME_GEN_FCS_EN.
- Defined: the FCS state transmits the computed CRC as above.
- Undefined:
  - No CRC logic is instantiated.
  - The FCS state is skipped; PAYLOAD goes directly to IFG.
  - Frame is 60 bytes at default parameters.
  - frame_count_out increments after the last payload nibble.

Decomposition:
- Package eth_test_frame_gen_pkg:
  - State enum (IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG).
  - Constants: PREAMBLE_NIBBLE 4'h5, SFD_NIBBLE 4'hD, CRC_POLY 32'hEDB8_8320, CRC_INIT 32'hFFFF_FFFF, CRC_RESIDUE 32'hDEBB_20E3.
- One sub-module, eth_crc32_nibble: combinational next-CRC from current CRC and a 4-bit nibble.

Test Plan:
- Reset:
  - rst_in high 3 cycles with enable_in high -> TX_EN = 0, TXD = 0, busy = 0, frame_count = 0 throughout.
  - After release, TX_EN rises exactly 2 cycles later.
- Single frame:
  - Pulse enable_in one cycle -> 15 nibbles 5, then D.
  - Header nibbles start F,F,... (broadcast); SRC nibbles 2,0,0,0,...,1,0.
  - EtherType nibbles 8,8,5,B.
  - Payload starts 0,0,0,0,2,0,3,0.
  - TX_EN high exactly 144 cycles; frame_count = 1.
- FCS check (macro defined):
  - Run the receiver CRC over header+payload+FCS nibbles -> register equals 32'hDEBB_20E3.
  - Run for frames 0..3 -> residue correct for every frame.
- Continuous: enable_in held high for 3 frames -> exactly 24 TX_EN-low cycles between frames; payload stamps 0x0000, 0x0001, 0x0002.
- Mid-frame events:
  - Drop enable_in at header nibble 10 -> frame completes, then IDLE, busy = 0 after IFG.
  - Assert rst_in during payload -> TX_EN low next cycle, frame_count unchanged.
- Wrap: force frame_count to 16'hFFFF -> next completed frame yields 0; that frame's stamp = FF,FF.
